ddr1_host_master: RTL and testbench

Host-side initiator for the DDR1 controller's request/response interface. Buffers upstream commands in a small FIFO and issues them one at a time on req_valid/req_ack. Tracks the single outstanding read and returns its data on a one-cycle output pulse. Sits between a traffic source (CPU/bus bridge or bench sequencer) and the DDR1 controller, replacing hand-driven host stimulus.

---
 rtl/ddr1_host_master.sv | 172 +++++++++++++++++
 tb/tb_ddr1_host_master.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr1_host_master.sv
// ddr1_host_master
// Host-side initiator for the DDR1 controller request/response interface.
// Upstream commands are queued in a small FIFO. They are issued one at a time
// on req_valid/req_ack. The single outstanding read is tracked until its data
// comes back, and that data is returned on a one-cycle rd_valid pulse.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   cmd_valid/cmd_ready          upstream command handshake (cmd_ready = !full)
//   cmd_rw/cmd_addr/cmd_wdata    command direction, {bank,row,col} address, write data
//   req_valid/req_ack            request handshake towards the controller
//   req_rw/req_addr/req_wdata    request payload, held stable while req_valid
//   resp_valid/resp_rdata        read data returned by the controller
//   rd_valid/rd_data/rd_addr     one-cycle read return pulse with its address
//   busy                         work pending or in flight
//   err_timeout/err_spurious     sticky error flags
//   wr_count/rd_count            completed write / read counters (wrap)
module ddr1_host_master #(
  parameter int FIFO_DEPTH   = 4,
  parameter int INIT_WAIT    = 300,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [24:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        req_valid,
  output logic        req_rw,
  output logic [24:0] req_addr,
  output logic [15:0] req_wdata,
  input  logic        req_ack,
  input  logic        resp_valid,
  input  logic [15:0] resp_rdata,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic [24:0] rd_addr,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_spurious,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
);

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam int ENT_W  = 1 + ADDR_W + DATA_W;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int IW     = $clog2(INIT_WAIT + 1);
  localparam int TW     = $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Command FIFO
  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      fifo_cnt;
  logic             full, empty, push;

  logic [IW-1:0]     init_cnt;
  logic [TW-1:0]     timer;
  logic [ADDR_W-1:0] pend_addr;

  // Per-cycle control strobes decoded from state and inputs
  logic init_done, pop, wr_done, rd_acc, rd_resp, rd_to;

  assign full      = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign empty     = (fifo_cnt == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign busy      = ((state != S_IDLE) && (state != S_INIT)) || !empty;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (init_cnt == IW'(INIT_WAIT - 1)) state_nxt = S_IDLE;
      S_IDLE:  if (!empty) state_nxt = S_ISSUE;
      S_ISSUE: if (req_ack) state_nxt = req_rw ? S_WAIT : S_IDLE;
      S_WAIT:  if (resp_valid || (timer == TW'(RESP_TIMEOUT - 1))) state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  // Control strobes. A response on the timeout edge wins over the timeout.
  always_comb begin
    init_done = (state == S_INIT) && (init_cnt == IW'(INIT_WAIT - 1));
    pop       = (state == S_IDLE) && !empty;
    wr_done   = (state == S_ISSUE) && req_ack && !req_rw;
    rd_acc    = (state == S_ISSUE) && req_ack && req_rw;
    rd_resp   = (state == S_WAIT) && resp_valid;
    rd_to     = (state == S_WAIT) && !resp_valid && (timer == TW'(RESP_TIMEOUT - 1));
  end

  // FIFO storage carries no reset; only the pointers and the count define its contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_rw, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      init_cnt     <= '0;
      timer        <= '0;
      pend_addr    <= '0;
      req_valid    <= 1'b0;
      req_rw       <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      rd_addr      <= '0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
      wr_count     <= '0;
      rd_count     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase

      if ((state == S_INIT) && !init_done) init_cnt <= init_cnt + IW'(1);

      if (pop) begin
        {req_rw, req_addr, req_wdata} <= fifo_mem[rd_ptr];
        req_valid <= 1'b1;
      end else if (wr_done || rd_acc) begin
        req_valid <= 1'b0;
      end

      if (rd_acc) begin
        pend_addr <= req_addr;
        timer     <= '0;
      end else if (state == S_WAIT) begin
        timer <= timer + TW'(1);
      end

      rd_valid <= rd_resp;
      if (rd_resp) begin
        rd_data  <= resp_rdata;
        rd_addr  <= pend_addr;
        rd_count <= rd_count + 16'd1;
      end

      if (wr_done) wr_count <= wr_count + 16'd1;
      if (rd_to) err_timeout <= 1'b1;
      if (resp_valid && (state != S_WAIT)) err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr1_host_master.sv
module tb_ddr1_host_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [24:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        req_valid, req_rw, req_ack;
  logic [24:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [24:0] rd_addr;
  logic        busy, err_timeout, err_spurious;
  logic [15:0] wr_count, rd_count;

  always #5 clk = ~clk;

  ddr1_host_master #(.FIFO_DEPTH(4), .INIT_WAIT(300), .RESP_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ack(req_ack),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_addr(rd_addr),
    .busy(busy), .err_timeout(err_timeout), .err_spurious(err_spurious),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  typedef struct {
    logic        rw;
    logic [24:0] addr;
    logic [15:0] data;
  } req_t;

  typedef struct {
    logic [15:0] data;
    logic [24:0] addr;
  } rd_t;

  typedef struct {
    logic        rw;
    logic [24:0] addr;
    logic [15:0] wdata;
    int          ack_dly;
    int          resp_dly;
    logic [15:0] exp_rdata;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rd_pulses = 0;
  int   exp_wr = 0;
  int   exp_rdc = 0;
  logic prev_rv = 1'b0;
  req_t cap;
  req_t exp_req[$];
  rd_t  exp_rd[$];
  logic [15:0] dram [logic [24:0]];
  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: outputs are observed on the falling edge, where the
  // request and read-return scoreboards are checked.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (req_valid && !prev_rv) begin
      if (exp_req.size() == 0) begin
        chk("req_unexpected", 64'd1, 64'd0);
      end else begin
        req_t e;
        e = exp_req.pop_front();
        chk("req_rw", req_rw, e.rw);
        chk("req_addr", req_addr, e.addr);
        chk("req_wdata", req_wdata, e.data);
      end
      cap = '{req_rw, req_addr, req_wdata};
    end else if (req_valid) begin
      chk("req_stable", {req_rw, req_addr, req_wdata}, {cap.rw, cap.addr, cap.data});
    end
    if (rd_valid) begin
      rd_pulses++;
      if (exp_rd.size() == 0) begin
        chk("rd_unexpected", 64'd1, 64'd0);
      end else begin
        rd_t r;
        r = exp_rd.pop_front();
        chk("rd_data", rd_data, r.data);
        chk("rd_addr", rd_addr, r.addr);
      end
    end
    prev_rv = req_valid;
  endtask

  task automatic push_cmd(input logic rw, input logic [24:0] addr, input logic [15:0] wd);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wd;
    if (cmd_ready) exp_req.push_back('{rw, addr, wd});
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!req_valid && n < 500) begin
      tick();
      n++;
    end
    chk("req_seen", req_valid, 1'b1);
  endtask

  task automatic serve(input int ack_dly);
    wait_req();
    if (req_valid) begin
      repeat (ack_dly) tick();
      req_ack = 1'b1;
      tick();
      req_ack = 1'b0;
      chk("req_drop", req_valid, 1'b0);
      if (!cap.rw) dram[cap.addr] = cap.data;
    end
  endtask

  // Stand-in controller: returns what the bench memory holds, while the
  // expected value comes from the caller.
  task automatic respond(input int dly, input logic [15:0] exp_data, input logic [24:0] exp_addr);
    repeat (dly) tick();
    resp_valid = 1'b1;
    resp_rdata = dram.exists(cap.addr) ? dram[cap.addr] : 16'h0000;
    exp_rd.push_back('{exp_data, exp_addr});
    tick();
    resp_valid = 1'b0;
    resp_rdata = 16'h0000;
  endtask

  initial begin
    int   n;
    int   nacc;
    int   pulses_before;
    logic saw;

    tbl[0] = '{1'b0, 25'h0012345, 16'h5A5A, 1, 0, 16'h0000};
    tbl[1] = '{1'b1, 25'h0012345, 16'h0000, 0, 3, 16'h5A5A};
    tbl[2] = '{1'b0, 25'h1FFFFFF, 16'hFFFF, 2, 0, 16'h0000};
    tbl[3] = '{1'b1, 25'h1FFFFFF, 16'h0000, 2, 0, 16'hFFFF};
    tbl[4] = '{1'b1, 25'h0000000, 16'h0000, 0, 1, 16'hABCD};
    tbl[5] = '{1'b0, 25'h0000000, 16'h0000, 0, 0, 16'h0000};
    tbl[6] = '{1'b1, 25'h0000000, 16'h0000, 1, 5, 16'h0000};
    tbl[7] = '{1'b0, 25'h1555555, 16'hC3C3, 0, 0, 16'h0000};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    req_ack = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
    repeat (10) tick();

    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_req", {req_valid, req_rw, req_addr, req_wdata}, 64'd0);
    chk("rst_rd", {rd_valid, rd_data, rd_addr}, 64'd0);
    chk("rst_flags", {busy, err_timeout, err_spurious}, 64'd0);
    chk("rst_counts", {wr_count, rd_count}, 64'd0);

    // Write queued during INIT must wait out the init period.
    rst = 1'b0;
    cyc = 0;
    while (cyc < 4) tick();
    push_cmd(1'b0, 25'h0000000, 16'hABCD);
    chk("init_busy_queued", busy, 1'b1);
    saw = 1'b0;
    while (cyc < 300) begin
      tick();
      if (req_valid) saw = 1'b1;
    end
    chk("init_no_issue", saw, 1'b0);
    n = 0;
    while (!req_valid && n < 50) begin
      tick();
      n++;
    end
    chk("first_issue_after_init", (req_valid && cyc >= 301), 1'b1);
    serve(3);
    exp_wr++;
    chk("wr_count_first", wr_count, 16'(exp_wr));

    // Read back the first write.
    push_cmd(1'b1, 25'h0000000, 16'h0000);
    serve(0);
    respond(2, 16'hABCD, 25'h0000000);
    exp_rdc++;
    tick();
    chk("rd_pulse_one_cycle", rd_valid, 1'b0);
    chk("rd_pulses_first", rd_pulses, 1);
    chk("rd_count_first", rd_count, 16'(exp_rdc));

    for (int i = 0; i < 8; i++) begin
      push_cmd(tbl[i].rw, tbl[i].addr, tbl[i].wdata);
      serve(tbl[i].ack_dly);
      if (tbl[i].rw) begin
        respond(tbl[i].resp_dly, tbl[i].exp_rdata, tbl[i].addr);
        exp_rdc++;
      end else begin
        exp_wr++;
      end
      chk("tbl_wr_count", wr_count, 16'(exp_wr));
      chk("tbl_rd_count", rd_count, 16'(exp_rdc));
      chk("tbl_busy_idle", busy, 1'b0);
    end

    // Back-to-back pushes with no ack: one issuing plus four queued.
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_rw    = 1'b0;
      cmd_addr  = 25'h100 + 25'(i);
      cmd_wdata = 16'h1000 + 16'(i);
      if (cmd_ready) begin
        exp_req.push_back('{1'b0, cmd_addr, cmd_wdata});
        nacc++;
      end
      tick();
    end
    cmd_valid = 1'b0;
    chk("fifo_accepted", nacc, 5);
    chk("fifo_full_ready", cmd_ready, 1'b0);
    chk("fifo_full_busy", busy, 1'b1);
    for (int i = 0; i < 5; i++) serve(i % 2);
    exp_wr += 5;
    chk("fifo_wr_count", wr_count, 16'(exp_wr));
    chk("fifo_drained_ready", cmd_ready, 1'b1);
    chk("fifo_order_all_seen", exp_req.size(), 0);

    // Read that never gets a response, with a write queued behind it.
    pulses_before = rd_pulses;
    push_cmd(1'b1, 25'h0000007, 16'h0000);
    push_cmd(1'b0, 25'h0000008, 16'h7777);
    serve(0);
    n = 0;
    while (!err_timeout && n < 100) begin
      tick();
      n++;
    end
    chk("timeout_flag", err_timeout, 1'b1);
    chk("timeout_cycles", n, 64);
    chk("timeout_no_rd", rd_pulses, pulses_before);
    chk("timeout_rd_count", rd_count, 16'(exp_rdc));
    serve(1);
    exp_wr++;
    chk("after_timeout_wr", wr_count, 16'(exp_wr));

    // Response while idle.
    tick();
    chk("spurious_clear", err_spurious, 1'b0);
    resp_valid = 1'b1;
    resp_rdata = 16'hDEAD;
    tick();
    resp_valid = 1'b0;
    resp_rdata = 16'h0000;
    chk("spurious_flag", err_spurious, 1'b1);
    repeat (3) tick();
    chk("spurious_no_rd", rd_pulses, pulses_before);
    chk("spurious_rd_count", rd_count, 16'(exp_rdc));
    chk("timeout_sticky", err_timeout, 1'b1);

    // Reset while a request is being issued and more are queued.
    push_cmd(1'b0, 25'h20, 16'h2020);
    push_cmd(1'b0, 25'h21, 16'h2121);
    push_cmd(1'b1, 25'h22, 16'h0000);
    wait_req();
    rst = 1'b1;
    exp_req.delete();
    tick();
    chk("midrst_req_valid", req_valid, 1'b0);
    chk("midrst_ready", cmd_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_counts", {wr_count, rd_count}, 64'd0);
    chk("midrst_errs", {err_timeout, err_spurious}, 64'd0);
    rst = 1'b0;
    saw = 1'b0;
    repeat (320) begin
      tick();
      if (req_valid) saw = 1'b1;
    end
    chk("midrst_fifo_dropped", saw, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
